// File: rtl/xctcmsg_pkg.sv
// xctcmsg_pkg: shared message types and queue defaults for the xctcmsg network adapters
package xctcmsg_pkg;

    localparam int BUS_SEND_DEPTH_DEFAULT = 4;
    localparam int BUS_RECV_DEPTH_DEFAULT = 2;

    typedef struct packed {
        logic [31:0] address;
        logic [31:0] tag;
    } message_meta_t;

    typedef struct packed {
        message_meta_t meta;
        logic [63:0]   data;
    } interface_send_data_t;

    typedef interface_send_data_t interface_receive_data_t;

    function automatic bit is_pow2_depth(input int depth);
        return depth >= 2 && (depth & (depth - 1)) == 0;
    endfunction

endpackage

// File: rtl/xctcmsg_sync_fifo.sv
// xctcmsg_sync_fifo: power-of-2 synchronous FIFO with wrapping pointers and an occupancy counter
module xctcmsg_sync_fifo
    import xctcmsg_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic [WIDTH-1:0]         i_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_level,
    output logic [WIDTH-1:0]         o_head
);
    localparam int AW = $clog2(DEPTH);

    if (!is_pow2_depth(DEPTH)) begin : g_bad_depth
        $error("xctcmsg_sync_fifo: DEPTH must be a power of 2 and >= 2");
    end

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;

    // pointers wrap naturally at DEPTH; level tracks push/pop balance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (i_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_level <= r_level + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    // storage needs no reset; the head is masked while empty
    always_ff @(posedge clk) begin
        if (i_push) r_mem[r_wr_ptr] <= i_data;
    end

    assign o_full  = r_level == (AW+1)'(DEPTH);
    assign o_empty = r_level == '0;
    assign o_level = r_level;
    assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

endmodule

// File: rtl/bus_queue_adapter.sv
// bus_queue_adapter: queued bus adapter between loopback interceptor and message bus; XCTCMSG_BUS_STATS_EN adds saturating stats
module bus_queue_adapter
    import xctcmsg_pkg::*;
#(
    parameter int SEND_DEPTH = BUS_SEND_DEPTH_DEFAULT,
    parameter int RECV_DEPTH = BUS_RECV_DEPTH_DEFAULT
`ifdef XCTCMSG_BUS_STATS_EN
    ,parameter int STAT_W = 16
`endif
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          loopback_interface_valid,
    output logic                          interface_loopback_ready,
    input  interface_send_data_t          loopback_interface_data,
    output logic                          interface_loopback_valid,
    input  logic                          loopback_interface_ready,
    output interface_receive_data_t       interface_loopback_data,
    output logic                          bus_val_o,
    input  logic                          bus_ack_i,
    output logic [31:0]                   bus_dst_o,
    output logic [31:0]                   bus_tag_o,
    output logic [63:0]                   bus_msg_o,
    output logic                          bus_rdy_o,
    input  logic                          bus_val_i,
    input  logic [31:0]                   bus_src_i,
    input  logic [31:0]                   bus_tag_i,
    input  logic [63:0]                   bus_msg_i,
    output logic [$clog2(SEND_DEPTH):0]   send_level_o,
    output logic [$clog2(RECV_DEPTH):0]   recv_level_o
`ifdef XCTCMSG_BUS_STATS_EN
    ,output logic [STAT_W-1:0]            stat_sent_o,
    output logic [STAT_W-1:0]             stat_recv_o,
    output logic [STAT_W-1:0]             stat_stall_o
`endif
);
    localparam int MW = $bits(interface_send_data_t);

    logic                    w_send_push;
    logic                    w_send_pop;
    logic                    w_send_full;
    logic                    w_send_empty;
    interface_send_data_t    w_send_head;
    logic                    w_recv_push;
    logic                    w_recv_pop;
    logic                    w_recv_full;
    logic                    w_recv_empty;
    interface_receive_data_t w_recv_in;

    assign w_send_pop               = bus_val_o & bus_ack_i;
    assign interface_loopback_ready = !w_send_full | bus_ack_i;
    assign w_send_push              = loopback_interface_valid & interface_loopback_ready;
    assign bus_val_o                = !w_send_empty;
    assign bus_dst_o                = w_send_head.meta.address;
    assign bus_tag_o                = w_send_head.meta.tag;
    assign bus_msg_o                = w_send_head.data;

    // rdy derives only from the registered receive level, so it never sees loopback_interface_ready combinationally
    assign bus_rdy_o                = !w_recv_full;
    assign w_recv_push              = bus_val_i & bus_rdy_o;
    assign w_recv_pop               = interface_loopback_valid & loopback_interface_ready;
    assign interface_loopback_valid = !w_recv_empty;
    assign w_recv_in                = {bus_src_i, bus_tag_i, bus_msg_i};

    xctcmsg_sync_fifo #(.WIDTH(MW), .DEPTH(SEND_DEPTH)) u_send_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_send_push),
        .i_pop   (w_send_pop),
        .i_data  (loopback_interface_data),
        .o_full  (w_send_full),
        .o_empty (w_send_empty),
        .o_level (send_level_o),
        .o_head  (w_send_head)
    );

    xctcmsg_sync_fifo #(.WIDTH(MW), .DEPTH(RECV_DEPTH)) u_recv_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_recv_push),
        .i_pop   (w_recv_pop),
        .i_data  (w_recv_in),
        .o_full  (w_recv_full),
        .o_empty (w_recv_empty),
        .o_level (recv_level_o),
        .o_head  (interface_loopback_data)
    );

`ifdef XCTCMSG_BUS_STATS_EN
    logic [STAT_W-1:0] r_stat_sent;
    logic [STAT_W-1:0] r_stat_recv;
    logic [STAT_W-1:0] r_stat_stall;

    // saturating traffic and stall counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stat_sent  <= '0;
            r_stat_recv  <= '0;
            r_stat_stall <= '0;
        end else begin
            if (w_send_pop && !(&r_stat_sent)) r_stat_sent <= r_stat_sent + 1'b1;
            if (w_recv_push && !(&r_stat_recv)) r_stat_recv <= r_stat_recv + 1'b1;
            if (bus_val_o && !bus_ack_i && !(&r_stat_stall)) r_stat_stall <= r_stat_stall + 1'b1;
        end
    end

    assign stat_sent_o  = r_stat_sent;
    assign stat_recv_o  = r_stat_recv;
    assign stat_stall_o = r_stat_stall;
`endif

endmodule
